// File: rtl/othello_pkg.sv
// Shared Othello definitions: board geometry, cell and winner codes, the
// score_tally FSM state type and the winner decision helper.
package othello_pkg;

  localparam int unsigned BOARD_DIM   = 8;
  localparam int unsigned BOARD_CELLS = BOARD_DIM * BOARD_DIM;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_BLACK = 2'b01;
  localparam logic [1:0] WIN_WHITE = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } tally_state_t;

  // Winner code for a finished tally; only meaningful once the game is over.
  function automatic logic [1:0] pick_winner(input logic [6:0] black,
                                             input logic [6:0] white,
                                             input logic       over);
    logic [1:0] win;
    if (!over)              win = WIN_NONE;
    else if (black > white) win = WIN_BLACK;
    else if (white > black) win = WIN_WHITE;
    else                    win = WIN_DRAW;
    return win;
  endfunction

endpackage

// File: rtl/score_tally_bin2bcd7.sv
// bin2bcd7: combinational 7-bit binary to two-digit BCD (tens, ones).
// Ports:
//   value in  7 : binary value 0..127
//   tens  out 4 : value / 10
//   ones  out 4 : value % 10
module bin2bcd7 (
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;

  // Repeated subtraction; 12 steps covers the full 7-bit range.
  always_comb begin
    rem  = value;
    tens = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
  end

endmodule

// File: rtl/score_tally.sv
// score_tally: scans the 64 board cells through a synchronous read port,
// counts black/white/empty cells and commits counts, game-over, winner and
// BCD score digits in one registered update.
// Ports:
//   clock, resetn (async, active-high reset)
//   start            : scan request, honoured while busy=0
//   rd_x, rd_y, rd_q : board read port (data one cycle after address)
//   busy, done       : scan in progress / one-cycle commit pulse
//   black_count, white_count, empty_count : last committed counts
//   game_over, winner                     : end-of-game status
//   black_tens .. white_ones              : BCD digits for the HEX displays
module score_tally #(
  parameter int unsigned BOARD_DIM  = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  input  logic [1:0] rd_q,
  output logic       busy,
  output logic       done,
  output logic [6:0] black_count,
  output logic [6:0] white_count,
  output logic [6:0] empty_count,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] black_tens,
  output logic [3:0] black_ones,
  output logic [3:0] white_tens,
  output logic [3:0] white_ones
);

  import othello_pkg::*;

  localparam logic [5:0] LAST_ADDR = 6'(BOARD_DIM * BOARD_DIM - 1);

  tally_state_t state, state_nxt;
  logic                  enter_scan;
  logic [5:0]            addr;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic                  vld;
  logic [6:0]            acc_black, acc_white, acc_empty;
  logic [6:0]            sum_black, sum_white, sum_empty;
  logic                  over_nxt;
  logic [3:0]            bt_nxt, bo_nxt, wt_nxt, wo_nxt;

  assign vld  = vld_pipe[RD_LATENCY-1];
  assign busy = (state == ST_SCAN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign rd_x = (state == ST_SCAN) ? addr[2:0] : 3'd0;
  assign rd_y = (state == ST_SCAN) ? addr[5:3] : 3'd0;

  always_comb begin
    state_nxt  = state;
    enter_scan = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_SCAN;
          enter_scan = 1'b1;
        end
      end
      ST_SCAN: begin
        if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_nxt  = ST_SCAN;
          enter_scan = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Accumulators including the read currently on rd_q; the commit in DRAIN
  // uses these so the final cell is counted without an extra cycle.
  always_comb begin
    sum_black = acc_black;
    sum_white = acc_white;
    sum_empty = acc_empty;
    if (vld) begin
      case (rd_q)
        CELL_BLACK: sum_black = acc_black + 7'd1;
        CELL_WHITE: sum_white = acc_white + 7'd1;
        default:    sum_empty = acc_empty + 7'd1; // empty or reserved
      endcase
    end
  end

  assign over_nxt = (sum_empty == 7'd0) || (sum_black == 7'd0) ||
                    (sum_white == 7'd0);

  bin2bcd7 u_bcd_black (
    .value (sum_black),
    .tens  (bt_nxt),
    .ones  (bo_nxt)
  );

  bin2bcd7 u_bcd_white (
    .value (sum_white),
    .tens  (wt_nxt),
    .ones  (wo_nxt)
  );

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state     <= ST_IDLE;
      addr      <= '0;
      vld_pipe  <= '0;
      acc_black <= '0;
      acc_white <= '0;
      acc_empty <= '0;
    end else begin
      state       <= state_nxt;
      vld_pipe[0] <= (state == ST_SCAN);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      if (enter_scan) begin
        addr      <= '0;
        acc_black <= '0;
        acc_white <= '0;
        acc_empty <= '0;
      end else begin
        if (state == ST_SCAN) addr <= addr + 6'd1;
        acc_black <= sum_black;
        acc_white <= sum_white;
        acc_empty <= sum_empty;
      end
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      black_count <= '0;
      white_count <= '0;
      empty_count <= '0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
      black_tens  <= '0;
      black_ones  <= '0;
      white_tens  <= '0;
      white_ones  <= '0;
    end else if (state == ST_DRAIN) begin
      black_count <= sum_black;
      white_count <= sum_white;
      empty_count <= sum_empty;
      game_over   <= over_nxt;
      winner      <= pick_winner(sum_black, sum_white, over_nxt);
      black_tens  <= bt_nxt;
      black_ones  <= bo_nxt;
      white_tens  <= wt_nxt;
      white_ones  <= wo_nxt;
    end
  end

endmodule

// File: tb/tb_score_tally.sv
module tb_score_tally;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [2:0] rd_x, rd_y;
  logic [1:0] rd_q = 2'b00;
  logic       busy, done;
  logic [6:0] black_count, white_count, empty_count;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] black_tens, black_ones, white_tens, white_ones;

  score_tally #(.BOARD_DIM(8), .RD_LATENCY(1)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_q        (rd_q),
    .busy        (busy),
    .done        (done),
    .black_count (black_count),
    .white_count (white_count),
    .empty_count (empty_count),
    .game_over   (game_over),
    .winner      (winner),
    .black_tens  (black_tens),
    .black_ones  (black_ones),
    .white_tens  (white_tens),
    .white_ones  (white_ones)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int b, w, e, go, win, bt, bo, wt, wo;
  } exp_t;

  logic [1:0] board [64];
  exp_t       q[$];
  exp_t       committed;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [39:0] dut_out;

  assign dut_out = {black_count, white_count, empty_count, game_over, winner,
                    black_tens, black_ones, white_tens, white_ones};

  // Board RAM stand-in: registered read, one cycle latency.
  always @(posedge clock) begin
    rd_q <= board[{rd_y, rd_x}];
    cyc  <= cyc + 1;
  end

  function automatic exp_t zero_exp();
    exp_t z;
    z = '{default: 0};
    return z;
  endfunction

  // Reference: tally the board array directly and apply the scoring rules.
  function automatic exp_t model(int due);
    exp_t x;
    x = '{default: 0};
    x.due = due;
    for (int i = 0; i < 64; i++) begin
      if (board[i] == 2'b01)      x.b++;
      else if (board[i] == 2'b10) x.w++;
      else                        x.e++;
    end
    x.go = (x.e == 0 || x.b == 0 || x.w == 0) ? 1 : 0;
    if (x.go == 0)      x.win = 0;
    else if (x.b > x.w) x.win = 1;
    else if (x.w > x.b) x.win = 2;
    else                x.win = 3;
    x.bt = x.b / 10; x.bo = x.b % 10;
    x.wt = x.w / 10; x.wo = x.w % 10;
    return x;
  endfunction

  function automatic logic [39:0] pack_exp(exp_t x);
    return {7'(x.b), 7'(x.w), 7'(x.e), 1'(x.go), 2'(x.win),
            4'(x.bt), 4'(x.bo), 4'(x.wt), 4'(x.wo)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every done, checks busy and that the
  // outputs always equal the last committed result.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("black_count", int'(black_count), e.b);
        chk("white_count", int'(white_count), e.w);
        chk("empty_count", int'(empty_count), e.e);
        chk("game_over", int'(game_over), e.go);
        chk("winner", int'(winner), e.win);
        committed = e;
      end
    end else if (q.size() > 0 && cyc >= q[0].due) begin
      chk("missing_done", 0, 1);
      void'(q.pop_front());
    end
    chk("busy", int'(busy),
        (q.size() > 0 && cyc >= q[0].due - 65 && cyc < q[0].due) ? 1 : 0);
    checks++;
    if (dut_out !== pack_exp(committed)) begin
      errors++;
      $display("FAIL outputs_hold: got %h expected %h (cycle %0d)",
               dut_out, pack_exp(committed), cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic issue_start();
    start = 1'b1;
    q.push_back(model(cyc + 1 + 65));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk("scan_timeout", q.size(), 0);
    q.delete();
    tick();
  endtask

  task automatic set_all(logic [1:0] v);
    for (int i = 0; i < 64; i++) board[i] = v;
  endtask

  task automatic shuffle_fill(int nb, int nw);
    logic [1:0] t;
    int j;
    for (int i = 0; i < 64; i++)
      board[i] = (i < nb) ? 2'b01 : (i < nb + nw) ? 2'b10 : 2'b00;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = board[i]; board[i] = board[j]; board[j] = t;
    end
  endtask

  task automatic random_board();
    for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic scan_and_check_digits(int bt, int bo, int wt, int wo, int win);
    issue_start();
    wait_drain(100);
    chk("black_tens", int'(black_tens), bt);
    chk("black_ones", int'(black_ones), bo);
    chk("white_tens", int'(white_tens), wt);
    chk("white_ones", int'(white_ones), wo);
    chk("winner_const", int'(winner), win);
  endtask

  initial begin
    int e0;
    committed = zero_exp();
    set_all(2'b00);
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_outputs", int'(dut_out != '0), 0);
    tick();
    resetn = 1'b0;
    tick();

    // Opening position: black (3,4),(4,3); white (3,3),(4,4)
    set_all(2'b00);
    board[4*8+3] = 2'b01; board[3*8+4] = 2'b01;
    board[3*8+3] = 2'b10; board[4*8+4] = 2'b10;
    scan_and_check_digits(0, 2, 0, 2, 0);
    chk("init_empty", int'(empty_count), 60);
    chk("init_game_over", int'(game_over), 0);

    shuffle_fill(40, 24);
    scan_and_check_digits(4, 0, 2, 4, 1);
    chk("full_game_over", int'(game_over), 1);

    set_all(2'b10);
    scan_and_check_digits(0, 0, 6, 4, 2);
    chk("white64_black", int'(black_count), 0);

    for (int i = 0; i < 64; i++) board[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    scan_and_check_digits(3, 2, 3, 2, 3);
    board[5] = 2'b11; board[40] = 2'b11;
    issue_start();
    wait_drain(100);
    chk("reserved_empty", int'(empty_count), 2);
    chk("reserved_game_over", int'(game_over), 0);
    chk("reserved_winner", int'(winner), 0);

    set_all(2'b00);
    scan_and_check_digits(0, 0, 0, 0, 3);

    // start pulses during a scan are ignored
    random_board();
    e0 = cyc + 1;
    issue_start();
    while (cyc < e0 + 9) tick();
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < e0 + 39) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_drain(100);
    repeat (80) tick();

    // reset in mid-scan: everything clears, no commit
    shuffle_fill(20, 30);
    e0 = cyc + 1;
    issue_start();
    while (cyc < e0 + 29) tick();
    resetn = 1'b1;
    q.delete();
    committed = zero_exp();
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_outputs", int'(dut_out != '0), 0);
    tick(); tick();
    resetn = 1'b0;
    repeat (80) tick();
    issue_start();
    wait_drain(100);

    // start held high: back-to-back scans every 66 cycles
    random_board();
    e0 = cyc + 1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      while (cyc < e0 + 66 * i - 1) tick();
      if (i > 0) random_board();
      q.push_back(model(e0 + 66 * i + 65));
    end
    while (cyc < e0 + 197) tick();
    start = 1'b0;
    wait_drain(100);
    repeat (70) tick();

    for (int k = 0; k < 5; k++) begin
      random_board();
      issue_start();
      wait_drain(100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/score_tally.md
# score_tally

Board scoring stage for the Othello design. It sits downstream of `board_ram`. On request it scans all 64 cells through a synchronous read port and counts black, white and empty cells. It then derives the `win` / game-over condition, which is currently tied to 0 at the top level, and produces BCD digits that drive the HEX score displays.

## Interface
- `BOARD_DIM`, default 8: cells per side. The block is only defined for 8, which gives 64 cells, 6-bit addresses and 7-bit counts.
- `RD_LATENCY`, default 1: read latency of the board port in cycles. Only 1 is supported.

Ports:
- `clock` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-high reset (driven by `restart`). The name follows the codebase; the polarity is high.
- `start` in 1: request a scan. Sampled only when `busy`=0.
- `rd_x` out 3: cell column for the board read.
- `rd_y` out 3: cell row for the board read.
- `rd_q` in 2: cell contents, valid one cycle after the address.
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse; results updated this cycle.
- `black_count`, `white_count`, `empty_count` out 7 each: results of the last completed scan.
- `game_over` out 1: feeds the `win` input of `control`.
- `winner` out 2: 00 none, 01 black, 10 white, 11 draw.
- `black_tens`, `black_ones`, `white_tens`, `white_ones` out 4 each: BCD digits for `hex_decoder`.

## Operation
- Cell encoding: 00 empty, 01 black, 10 white, 11 reserved. A reserved value is counted as empty, so the three counts always sum to 64.
- FSM states and transitions:
  - IDLE goes to SCAN when `start` is high.
  - SCAN issues addresses 0..63, one per cycle. It goes to DRAIN after address 63.
  - DRAIN accepts the final read and goes to DONE.
  - DONE goes to IDLE.
- Address mapping: the 6-bit address `a` gives `rd_x`=a[2:0] and `rd_y`=a[5:3]. In IDLE and DONE, `rd_x`/`rd_y` are 0.
- Accumulation:
  - Three internal 7-bit accumulators are cleared on entry to SCAN.
  - Each accumulates `rd_q` one cycle after its address, using a registered valid flag.
- Commit at the end of DRAIN, registered together:
  - The counts are copied to the outputs.
  - `game_over` = (empty==0) | (black==0) | (white==0).
  - `winner` = 00 if not `game_over`; otherwise 01 if black>white, 10 if white>black, 11 if equal.
  - BCD digits: tens = count/10 and ones = count%10, for counts 0..64.
- Outputs hold the previous results throughout a scan. They change only at commit.
- `start` handling:
  - `start` while `busy`=1 is ignored and not queued.
  - `start` is accepted in DONE and in IDLE, since `busy`=0 in both. When it is accepted in DONE, the FSM goes directly to SCAN.
- Reset values: every output, counter, accumulator and state register resets to 0 and the FSM to IDLE. Reset in mid-scan aborts the scan with no commit.

## Timing
- `start` sampled high at edge E0:
  - Address 0 is presented in cycle 1 and address 63 in cycle 64.
  - DRAIN is cycle 65.
  - `done`=1 in cycle 66, and the new outputs are valid from cycle 66.
- Scan duration: 66 cycles from `start` to `done`.
- `busy` is high in cycles 1..65 and low in DONE.
- `done` is high for exactly one cycle per completed scan.
- Back-to-back: `start` held high continuously produces one scan every 66 cycles.

## Structure
- Shared `othello_pkg` holds:
  - Cell codes: `CELL_EMPTY`, `CELL_BLACK`, `CELL_WHITE`.
  - Winner codes: `WIN_NONE`, `WIN_BLACK`, `WIN_WHITE`, `WIN_DRAW`.
  - `BOARD_DIM`, `BOARD_CELLS`=64.
- Sub-module `bin2bcd7`: combinational 7-bit to two-digit BCD conversion. Two instances, one for black and one for white, registered at commit.
- Single FSM plus a 6-bit address counter and a 1-cycle valid pipeline register.

## Test plan
- Initial board (black at (3,4),(4,3), white at (3,3),(4,4), rest empty), `start` pulse:
  - `done` exactly 66 cycles later.
  - Counts 2/2/60, `game_over`=0, `winner`=00, digits 0,2,0,2.
- Full board with 40 black and 24 white: `game_over`=1, `winner`=01, `black_tens`/`black_ones`=4/0, `white_tens`/`white_ones`=2/4.
- Board with 64 white: black 0, `game_over`=1, `winner`=10, `white_tens`/`white_ones`=6/4.
- Full board 32/32: `winner`=11. Same board with two cells set to 11: empty 2, `game_over`=0, `winner`=00.
- Mid-scan stimulus:
  - `start` pulses at cycles 10 and 40 are ignored; a single `done` occurs at cycle 66.
  - `resetn` asserted at cycle 30: all outputs 0, FSM in IDLE, no `done`.
- `start` held high: `done` pulses at cycles 66, 132 and 198. Change the board between scans and check that outputs update only on `done` cycles.
